a0_trace_fifo: RTL and testbench

- Downstream observer of the single-cycle CPU's A0 output register.
- Captures each new A0 value with a cycle timestamp into an on-chip FIFO.
- Host/testbench side drains entries over a valid/ready handshake.
- Used for F1-lights sequence checking and for display pacing without stalling the CPU.

---
 rtl/a0_trace_pkg.sv | 20 ++
 rtl/a0_trace_fifo_sync_fifo.sv | 53 +++++
 rtl/a0_trace_fifo.sv | 90 +++++++++
 tb/tb_a0_trace_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/a0_trace_pkg.sv
// Shared types and sizing helpers for the A0 trace FIFO.
// trace_entry_t matches the default configuration; parameterised tops build their own.
package a0_trace_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_TS_WIDTH = 16;
  localparam int PTR_W        = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_WIDTH-1:0]    data;
    logic [DEF_TS_WIDTH-1:0] ts;
  } trace_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/a0_trace_fifo_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through read data.
// Caller guarantees push is only asserted when !full || pop, and pop only when count != 0.
module sync_fifo #(
  parameter int  DEPTH   = 16,
  parameter type entry_t = logic [7:0],
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr_data,
  output entry_t           rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage has no reset: entries are only observable once count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/a0_trace_fifo.sv
// Captures every change of the CPU's A0 register with a cycle timestamp and
// queues it for a host to drain without ever stalling the CPU.
module a0_trace_fifo
  import a0_trace_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           a0_in,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TS_WIDTH-1:0]        out_ts,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow
);

  localparam int CNT_W = cnt_w(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0]    data;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  logic [TS_WIDTH-1:0] ts_q;
  logic [WIDTH-1:0]    prev_a0;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                drop;
  entry_t              wr_entry;
  entry_t              rd_entry;

  // Handshake: the head entry transfers on any clk edge where out_valid && out_ready;
  // out_valid never depends on out_ready and the head holds until it is taken.
  assign out_valid = (count != CNT_W'(0));
  assign pop       = out_valid && out_ready;

  assign push_req  = en && (a0_in != prev_a0);
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = a0_in;
    wr_entry.ts   = ts_q;
  end

  sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (count),
    .full    (full)
  );

  assign out_data = rd_entry.data;
  assign out_ts   = rd_entry.ts;

  // prev_a0 tracks a0_in unconditionally, so a value dropped while full is never retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q     <= '0;
      prev_a0  <= '0;
      overflow <= 1'b0;
    end else begin
      ts_q    <= ts_q + TS_WIDTH'(1);
      prev_a0 <= a0_in;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed bench for a0_trace_fifo: a per-cycle vector table plus hand-written
// sequences for overflow, full-with-pop, timestamp wrap and mid-drain reset.
module tb_a0_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a0_in;
  logic        clr_ovf;
  logic        out_ready;

  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] out_ts;
  logic [4:0]  count;
  logic        full;
  logic        overflow;

  logic        v4;
  logic [31:0] d4;
  logic [3:0]  ts4;
  logic [4:0]  cnt4;
  logic        full4;
  logic        ovf4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  a0_trace_fifo #(.WIDTH(32), .DEPTH(16), .TS_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .a0_in     (a0_in),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ts    (out_ts),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  a0_trace_fifo #(.WIDTH(32), .DEPTH(16), .TS_WIDTH(4)) dut_ts4 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .a0_in     (a0_in),
    .clr_ovf   (clr_ovf),
    .out_valid (v4),
    .out_ready (out_ready),
    .out_data  (d4),
    .out_ts    (ts4),
    .count     (cnt4),
    .full      (full4),
    .overflow  (ovf4)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b1;
    a0_in     = '0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        en;
    logic [31:0] a0;
    logic        rdy;
    logic        v;
    logic [31:0] d;
    logic [15:0] ts;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Row i is applied before post-reset edge i, whose timestamp is i.
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0, 5'd0};
    vecs[5]  = '{1'b1, 32'h1, 1'b0, 1'b1, 32'h1, 16'd5,  5'd1};
    vecs[6]  = '{1'b1, 32'h1, 1'b0, 1'b1, 32'h1, 16'd5,  5'd1};
    vecs[7]  = '{1'b1, 32'h1, 1'b0, 1'b1, 32'h1, 16'd5,  5'd1};
    vecs[8]  = '{1'b1, 32'h1, 1'b1, 1'b0, 32'h0, 16'd0,  5'd0};
    vecs[9]  = '{1'b0, 32'h2, 1'b0, 1'b0, 32'h0, 16'd0,  5'd0};
    vecs[10] = '{1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 16'd0,  5'd0};
    vecs[11] = '{1'b1, 32'h3, 1'b0, 1'b1, 32'h3, 16'd11, 5'd1};
    vecs[12] = '{1'b1, 32'h4, 1'b0, 1'b1, 32'h3, 16'd11, 5'd2};
    vecs[13] = '{1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 16'd12, 5'd1};
    vecs[14] = '{1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 16'd0,  5'd0};

    // Reset state and idle with A0 held at zero
    do_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_count", count, 5'd0);
      chk("idle_ovf", overflow, 1'b0);
    end

    // Vector table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      en        = vecs[i].en;
      a0_in     = vecs[i].a0;
      out_ready = vecs[i].rdy;
      tick();
      chk("vec_valid", out_valid, vecs[i].v);
      chk("vec_count", count, vecs[i].cnt);
      if (vecs[i].v) begin
        chk("vec_data", out_data, vecs[i].d);
        chk("vec_ts", out_ts, vecs[i].ts);
      end
    end

    // Overflow: 17 distinct values into 16 slots
    do_reset();
    exp_q.delete();
    for (int v = 1; v <= 16; v++) begin
      a0_in = v;
      tick();
      exp_q.push_back(v);
    end
    chk("ovf_full16", full, 1'b1);
    chk("ovf_count16", count, 5'd16);
    chk("ovf_clear16", overflow, 1'b0);
    a0_in = 32'd17;
    tick();
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count17", count, 5'd16);
    tick();
    chk("ovf_no_retry", count, 5'd16);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk("ovf_drain_data", out_data, e);
      chk("ovf_drain_ts", out_ts, e - 32'd1);
      tick();
    end
    chk("ovf_drained_valid", out_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    out_ready = 1'b0;
    clr_ovf   = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Full with a same-cycle pop, then clear-versus-drop priority
    do_reset();
    exp_q.delete();
    for (int v = 1; v <= 16; v++) begin
      a0_in = v;
      tick();
      if (v > 1) exp_q.push_back(v);
    end
    chk("fp_full", full, 1'b1);
    a0_in     = 32'hAA;
    out_ready = 1'b1;
    tick();
    exp_q.push_back(32'hAA);
    chk("fp_count", count, 5'd16);
    chk("fp_full_after", full, 1'b1);
    chk("fp_no_ovf", overflow, 1'b0);
    chk("fp_head", out_data, 32'd2);
    out_ready = 1'b0;
    a0_in     = 32'hBB;
    tick();
    chk("fp_drop_ovf", overflow, 1'b1);
    chk("fp_drop_head", out_data, 32'd2);
    a0_in   = 32'hCC;
    clr_ovf = 1'b1;
    tick();
    chk("fp_drop_wins", overflow, 1'b1);
    tick();
    clr_ovf = 1'b0;
    chk("fp_clr", overflow, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk("fp_drain_data", out_data, e);
      tick();
    end
    chk("fp_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // Timestamp wrap on the 4-bit instance: captures at counter 14 and 17
    do_reset();
    for (int i = 0; i < 14; i++) tick();
    a0_in = 32'd5;
    tick();
    tick();
    tick();
    a0_in = 32'd6;
    tick();
    chk("ts4_count", cnt4, 5'd2);
    chk("ts4_data0", d4, 32'd5);
    chk("ts4_ts0", ts4, 4'd14);
    chk("ts16_ts0", out_ts, 16'd14);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ts4_data1", d4, 32'd6);
    chk("ts4_wrap", ts4, 4'd1);
    chk("ts16_ts1", out_ts, 16'd17);

    // Reset in the middle of a drain
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      a0_in = v;
      tick();
    end
    chk("mr_count5", count, 5'd5);
    out_ready = 1'b1;
    tick();
    chk("mr_count4", count, 5'd4);
    rst   = 1'b1;
    a0_in = 32'd9;
    tick();
    chk("mr_count0", count, 5'd0);
    chk("mr_valid0", out_valid, 1'b0);
    chk("mr_ovf0", overflow, 1'b0);
    chk("mr_full0", full, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b0;
    a0_in     = 32'd3;
    tick();
    chk("mr_valid1", out_valid, 1'b1);
    chk("mr_data", out_data, 32'd3);
    chk("mr_ts", out_ts, 16'd0);
    chk("mr_count1", count, 5'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
